// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART core.
// State encodings for both directions and the frame data width.
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        TX_CLEANUP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_CLEANUP
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserialiser with a two-flop input synchroniser.
// Samples mid-bit; a low stop bit drops the frame without a strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_uart_rx,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        sync1;
    logic        sync2;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            state     <= RX_IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= '0;
        end else begin
            sync1   <= i_uart_rx;
            sync2   <= sync1;
            o_RX_DV <= 1'b0;
            case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!sync2) state <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF) begin
                        cnt   <= '0;
                        state <= sync2 ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == LAST) begin
                        cnt        <= '0;
                        shreg[idx] <= sync2;
                        if (idx == LAST_BIT) begin
                            state <= RX_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= RX_CLEANUP;
                        if (sync2) begin
                            o_RX_Byte <= shreg;
                            o_RX_DV   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_CLEANUP: state <= RX_IDLE;
                default:    state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serialiser: one start bit, eight data bits LSB first, one stop bit.
// Line, active and done are registered so reset forces them immediately.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_uart_tx,
    output logic       o_TX_Done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t   state;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  data;
    logic        line;
    logic        busy;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state <= TX_IDLE;
            cnt   <= '0;
            idx   <= '0;
            data  <= '0;
        end else begin
            case (state)
                TX_IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (i_TX_DV) begin
                        data  <= i_TX_Byte;
                        state <= TX_START;
                    end
                end
                TX_START: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= TX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (idx == LAST_BIT) begin
                            state <= TX_STOP;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= TX_CLEANUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TX_CLEANUP: state <= TX_IDLE;
                default:    state <= TX_IDLE;
            endcase
        end
    end

    always_comb begin
        line = 1'b1;
        case (state)
            TX_START: line = 1'b0;
            TX_DATA:  line = data[idx];
            default:  line = 1'b1;
        endcase
    end

    assign busy = (state == TX_START) || (state == TX_DATA) ||
                  (state == TX_STOP);

    // One register stage behind the FSM: line moves the cycle after DV.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            o_uart_tx   <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            o_uart_tx   <= line;
            o_TX_Active <= busy;
            o_TX_Done   <= (state == TX_CLEANUP);
        end
    end

endmodule

// File: rtl/uart_txrx.sv
// Full-duplex 8N1 UART: independent transmitter and receiver halves
// sharing only clock, reset and the bit-period parameter.
module uart_txrx #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_TX_Active,
    output logic       o_uart_tx,
    output logic       o_TX_Done,
    input  logic       i_uart_rx,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte
);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .i_Clock     (i_Clock),
        .i_Reset     (i_Reset),
        .i_TX_DV     (i_TX_DV),
        .i_TX_Byte   (i_TX_Byte),
        .o_TX_Active (o_TX_Active),
        .o_uart_tx   (o_uart_tx),
        .o_TX_Done   (o_TX_Done)
    );

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_Clock   (i_Clock),
        .i_Reset   (i_Reset),
        .i_uart_rx (i_uart_rx),
        .o_RX_DV   (o_RX_DV),
        .o_RX_Byte (o_RX_Byte)
    );

endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx: loopback, waveform timing, back-to-back,
// glitch, framing error and mid-frame reset.
module tb_uart_txrx;

    localparam int CPB = 217;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_dv;
    logic [7:0] tx_byte;
    logic       tx_active;
    logic       uart_tx;
    logic       tx_done;
    logic       rx_drv;
    logic       uart_rx;
    logic       rx_dv;
    logic [7:0] rx_byte;

    int tests = 0;
    int fails = 0;
    int dv_cnt = 0;
    int done_cnt = 0;
    logic [7:0] rx_log[$];

    // The line seen by RX is the TX output, optionally pulled low by the bench.
    assign uart_rx = uart_tx & rx_drv;

    always #5 clk = ~clk;

    uart_txrx #(.CLKS_PER_BIT(CPB)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_TX_DV     (tx_dv),
        .i_TX_Byte   (tx_byte),
        .o_TX_Active (tx_active),
        .o_uart_tx   (uart_tx),
        .o_TX_Done   (tx_done),
        .i_uart_rx   (uart_rx),
        .o_RX_DV     (rx_dv),
        .o_RX_Byte   (rx_byte)
    );

    always @(negedge clk) begin
        if (rx_dv) begin
            dv_cnt++;
            rx_log.push_back(rx_byte);
        end
        if (tx_done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        tx_byte = b;
        tx_dv   = 1'b1;
        @(posedge clk);
        #1;
        tx_dv   = 1'b0;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (tx_done) ok = 1'b1;
        end
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            tick(CPB);
        end
        rx_drv = stop;
        tick(CPB);
        rx_drv = 1'b1;
    endtask

    logic [9:0] pat;
    logic       ok;
    int         base;
    int         snap;
    int         snap_done;
    logic [7:0] b0;
    logic [7:0] b1;

    initial begin
        rst     = 1'b1;
        tx_dv   = 1'b0;
        tx_byte = 8'h00;
        rx_drv  = 1'b1;
        tick(3);
        check("rst_tx", uart_tx, 1);
        check("rst_active", tx_active, 0);
        check("rst_done", tx_done, 0);
        check("rst_rx_dv", rx_dv, 0);
        check("rst_rx_byte", rx_byte, 8'h00);
        rst = 1'b0;
        tick(2);

        // Loopback of 0x3F
        send(8'h3F);
        tick(2300);
        check("lb_dv_cnt", dv_cnt, 1);
        check("lb_byte", rx_byte, 8'h3F);
        check("lb_done_cnt", done_cnt, 1);

        // Exact waveform of 0xA5: start, LSB-first data, stop
        pat = 10'b1101001010;
        send(8'hA5);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("wave_start_%0d", k), uart_tx, pat[k]);
            if (k == 0) check("wave_active_first", tx_active, 1);
            repeat (CPB - 1) @(posedge clk);
            #1;
            check($sformatf("wave_end_%0d", k), uart_tx, pat[k]);
        end
        check("wave_active_last", tx_active, 1);
        tick(1);
        check("wave_done_hi", tx_done, 1);
        check("wave_active_lo", tx_active, 0);
        check("wave_idle_line", uart_tx, 1);
        tick(1);
        check("wave_done_lo", tx_done, 0);
        check("wave_rx_byte", rx_byte, 8'hA5);
        check("wave_done_cnt", done_cnt, 2);

        // Back-to-back 0x00 then 0xFF; extra DV pulses while busy
        tick(20);
        base = rx_log.size();
        send(8'h00);
        wait_done(ok);
        check("b2b_done_seen", ok, 1);
        tx_byte = 8'hFF;
        tx_dv   = 1'b1;
        tick(1);
        tx_dv   = 1'b0;
        tick(500);
        send(8'h11);
        tick(300);
        send(8'h22);
        tick(2300);
        b0 = 8'hxx;
        b1 = 8'hxx;
        if (rx_log.size() > base) b0 = rx_log[base];
        if (rx_log.size() > base + 1) b1 = rx_log[base + 1];
        check("b2b_count", rx_log.size() - base, 2);
        check("b2b_first", b0, 8'h00);
        check("b2b_second", b1, 8'hFF);
        check("b2b_done_cnt", done_cnt, 4);
        check("b2b_idle", tx_active, 0);

        // 50-cycle glitch on an idle line
        snap = dv_cnt;
        rx_drv = 1'b0;
        tick(50);
        rx_drv = 1'b1;
        tick(400);
        check("glitch_no_dv", dv_cnt, snap);
        check("glitch_byte", rx_byte, 8'hFF);

        // Valid hand-driven frame proves RX went back to IDLE
        drive_frame(8'hC3, 1'b1);
        tick(300);
        check("manual_dv_cnt", dv_cnt, snap + 1);
        check("manual_byte", rx_byte, 8'hC3);

        // Framing error: stop bit held low
        drive_frame(8'h55, 1'b0);
        tick(500);
        check("frame_err_no_dv", dv_cnt, snap + 1);
        check("frame_err_byte", rx_byte, 8'hC3);

        // Reset in the middle of data bit 4
        snap      = dv_cnt;
        snap_done = done_cnt;
        send(8'h3C);
        tick(1 + 4 * CPB + 100);
        check("pre_rst_active", tx_active, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_tx", uart_tx, 1);
        check("mid_rst_active", tx_active, 0);
        check("mid_rst_rx_byte", rx_byte, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(10);
        check("post_rst_no_dv", dv_cnt, snap);
        send(8'h3C);
        tick(2300);
        check("post_rst_dv_cnt", dv_cnt, snap + 1);
        check("post_rst_byte", rx_byte, 8'h3C);
        check("post_rst_done_cnt", done_cnt, snap_done + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_txrx.md
# uart_txrx

Full-duplex 8N1 UART core: one transmitter serialises bytes onto `o_uart_tx`, and one receiver deserialises `i_uart_rx` into bytes. It sits between the system fabric and the board serial pins. Both directions run on one clock and share one bit-rate parameter. The two halves are independent; a loopback bench connects `o_uart_tx` to `i_uart_rx`.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per serial bit (100 MHz / 217 ≈ 460.8 kbaud); legal range ≥ 4.
- `i_Clock` in 1: sole clock; all logic on the rising edge.
- `i_Reset` in 1: reset, asynchronous and active-high.
- `i_TX_DV` in 1: one-cycle strobe requesting transmission of `i_TX_Byte`.
- `i_TX_Byte` in 8: byte to send; sampled only on an accepted `i_TX_DV`.
- `o_TX_Active` out 1: high while a frame is on the line (start through stop).
- `o_uart_tx` out 1: serial output; idles high.
- `o_TX_Done` out 1: one-cycle pulse after the stop bit completes.
- `i_uart_rx` in 1: asynchronous serial input; idles high.
- `o_RX_DV` out 1: one-cycle pulse when `o_RX_Byte` is updated with a valid frame.
- `o_RX_Byte` out 8: last received byte; holds its value between frames.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- TX FSM states are IDLE, START, DATA, STOP and CLEANUP.
  - IDLE: line high. `i_TX_DV` = 1 latches the byte and moves to START.
  - START: drive 0 for `CLKS_PER_BIT` cycles.
  - DATA: drive bit index 0..7, `CLKS_PER_BIT` cycles each.
  - STOP: drive 1 for `CLKS_PER_BIT` cycles.
  - CLEANUP: pulse `o_TX_Done` and deassert `o_TX_Active`, then return to IDLE.
- TX ignores `i_TX_DV` while not in IDLE; there is no queueing.
- RX input passes through a 2-flop synchroniser before use.
- RX FSM states are IDLE, START, DATA, STOP and CLEANUP.
  - IDLE: a synchronised low moves to START.
  - START: wait `(CLKS_PER_BIT-1)/2` cycles, then resample. Still low → DATA with the counter cleared; high → glitch, return to IDLE.
  - DATA: sample every `CLKS_PER_BIT` cycles (mid-bit) into bit index 0..7.
  - STOP: sample after `CLKS_PER_BIT` cycles. A 1 writes `o_RX_Byte` and pulses `o_RX_DV`. A 0 is a framing error: the byte is discarded, there is no pulse, and `o_RX_Byte` is unchanged.
  - CLEANUP: one cycle, then IDLE.
- Counters are sized `$clog2(CLKS_PER_BIT)` bits and must never wrap mid-bit. The bit index is 3 bits.

## Timing
- Reset values: `o_uart_tx` = 1, `o_TX_Active` = 0, `o_TX_Done` = 0, `o_RX_DV` = 0, `o_RX_Byte` = 0x00; both FSMs in IDLE.
- Reset asserted mid-frame aborts immediately; the line returns high asynchronously.
- `i_TX_DV` sampled high at edge N means `o_uart_tx` = 0 and `o_TX_Active` = 1 from edge N+1.
- Each bit lasts exactly `CLKS_PER_BIT` cycles.
- The stop bit ends at edge N+1+10·`CLKS_PER_BIT`. `o_TX_Done` is high for the following cycle, in which `o_TX_Active` = 0. A new `i_TX_DV` is accepted in that same cycle or later.
- RX: `o_RX_DV` pulses about 9.5 bit periods + 3 cycles after the start falling edge; `o_RX_Byte` is valid in the same cycle.
- RX re-arms for a back-to-back start bit immediately after the stop sample plus CLKS_PER_BIT cycle... specifically: the stop sample occurs mid stop bit, so RX re-arms within half a bit.

## Structure
- Package `uart_pkg` holds the TX and RX state enums and `DATA_BITS` = 8.
- Top `uart_txrx` instantiates two leaf sub-modules, `uart_tx` and `uart_rx`, each with its own bit counter and FSM. The only shared elements are the clock, reset and `CLKS_PER_BIT`.

## Test plan
- Loopback: send 0x3F → `o_RX_DV` pulses once with `o_RX_Byte` = 0x3F; `o_TX_Done` pulses once.
- Waveform check on 0xA5 → line pattern 0,1,0,1,0,0,1,0,1,1, each bit exactly 217 cycles; `o_TX_Active` spans 2170 cycles.
- Back-to-back 0x00 then 0xFF, with the second `i_TX_DV` issued in the `o_TX_Done` cycle → both bytes received in order; `i_TX_DV` pulses during busy are ignored.
- RX glitch: low pulse of 50 cycles on an idle line → no `o_RX_DV`, and RX returns to IDLE.
- Framing error: valid frame 0x55 with stop bit forced 0 → no `o_RX_DV`, `o_RX_Byte` unchanged.
- Reset mid-transmit at bit 4 → `o_uart_tx` = 1 and `o_TX_Active` = 0 immediately; the next send of 0x3C is received correctly.
